// File: rtl/wdt_pkg.sv
// Shared types and sizing helpers for the watchdog reset-request block.
package wdt_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      REQ
   } wdt_state_e;

   localparam int DefaultReqCycles = 4;
   localparam int ReqCntWidth      = $clog2(DefaultReqCycles + 1);

   function automatic int req_cnt_width(input int req_cycles);
      return $clog2(req_cycles + 1);
   endfunction

endpackage

// File: rtl/wdt_req_stretch.sv
// Stretches a one-cycle start strobe into a ReqCycles-long active-low request.
module wdt_req_stretch
   import wdt_pkg::*;
#(
   parameter int ReqCycles = DefaultReqCycles
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   output logic req_n,
   output logic done
);

   localparam int W = req_cnt_width(ReqCycles);
   localparam logic [W-1:0] Last = W'(ReqCycles - 1);

   logic [W-1:0] cnt_reg;
   logic         req_n_reg;

   // done marks the final low cycle so the owner can leave REQ on the same edge
   assign done  = !req_n_reg && (cnt_reg == Last);
   assign req_n = req_n_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_reg   <= '0;
         req_n_reg <= 1'b1;
      end else if (start) begin
         cnt_reg   <= '0;
         req_n_reg <= 1'b0;
      end else if (done) begin
         cnt_reg   <= '0;
         req_n_reg <= 1'b1;
      end else if (!req_n_reg) begin
         cnt_reg   <= cnt_reg + 1'b1;
      end
   end

endmodule

// File: rtl/wdt_rst_req.sv
// Watchdog timer: down-counter with kick, warning, and a timed active-low reset request.
module wdt_rst_req
   import wdt_pkg::*;
#(
   parameter int CntWidth       = 16,
   parameter int DefaultTimeout = 1000,
   parameter int WarnCycles     = 16,
   parameter int ReqCycles      = 4
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                en_i,
   input  logic                load_i,
   input  logic [CntWidth-1:0] load_val_i,
   input  logic                kick_i,
   input  logic                clr_i,
   output logic [CntWidth-1:0] cnt_o,
   output logic                warn_o,
   output logic                expired_o,
   output logic                rst_req_no
);

   localparam logic [CntWidth-1:0] ResetTimeout = CntWidth'(DefaultTimeout);

   wdt_state_e          state_reg;
   logic [CntWidth-1:0] timeout_reg;
   logic [CntWidth-1:0] cnt_reg;
   logic                expired_reg;
   logic                req_start;
   logic                req_done;

   // Expiry is decided here so the stretcher pulls the request low on the REQ entry edge
   assign req_start = (state_reg == RUN) && en_i && !kick_i && (cnt_reg == '0);

   wdt_req_stretch #(
      .ReqCycles(ReqCycles)
   ) u_stretch (
      .clk  (clk_i),
      .rst  (rst_i),
      .start(req_start),
      .req_n(rst_req_no),
      .done (req_done)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_reg   <= IDLE;
         timeout_reg <= ResetTimeout;
         cnt_reg     <= ResetTimeout;
         expired_reg <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (load_i) timeout_reg <= load_val_i;
               if (en_i) begin
                  state_reg <= RUN;
                  cnt_reg   <= timeout_reg;
               end else begin
                  cnt_reg   <= load_i ? load_val_i : timeout_reg;
               end
            end
            RUN: begin
               if (!en_i) begin
                  state_reg <= IDLE;
                  cnt_reg   <= timeout_reg;
               end else if (kick_i) begin
                  cnt_reg   <= timeout_reg;
               end else if (cnt_reg == '0) begin
                  state_reg <= REQ;
               end else begin
                  cnt_reg   <= cnt_reg - 1'b1;
               end
            end
            REQ: begin
               if (req_done) begin
                  state_reg <= IDLE;
                  cnt_reg   <= timeout_reg;
               end
            end
            default: state_reg <= IDLE;
         endcase

         if (req_done)   expired_reg <= 1'b1;
         else if (clr_i) expired_reg <= 1'b0;
      end
   end

   assign cnt_o     = cnt_reg;
   assign expired_o = expired_reg;
   assign warn_o    = (state_reg == RUN) && (32'(cnt_reg) <= WarnCycles);

endmodule

// File: tb/tb_wdt_rst_req.sv
// Scenario tasks plus a randomized run, all checked against a behavioural watchdog model.
module tb_wdt_rst_req;

   localparam int W    = 16;
   localparam int DEF  = 1000;
   localparam int WARN = 3;
   localparam int REQN = 4;

   logic         clk = 0;
   logic         rst = 0;
   logic         en = 0, load = 0, kick = 0, clr = 0;
   logic [W-1:0] load_val = '0;
   logic [W-1:0] cnt;
   logic         warn, expired, rst_req_n;

   int n_checks = 0;
   int n_pass   = 0;

   // model: mode 0=idle 1=run 2=req, req_left counts remaining low cycles
   int m_mode, m_cnt, m_to, m_left, m_exp;

   wdt_rst_req #(
      .CntWidth(W), .DefaultTimeout(DEF), .WarnCycles(WARN), .ReqCycles(REQN)
   ) dut (
      .clk_i(clk), .rst_i(rst), .en_i(en), .load_i(load), .load_val_i(load_val),
      .kick_i(kick), .clr_i(clr), .cnt_o(cnt), .warn_o(warn),
      .expired_o(expired), .rst_req_no(rst_req_n)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_mode = 0; m_cnt = DEF; m_to = DEF; m_left = 0; m_exp = 0;
   endtask

   task automatic model_edge();
      int  new_to;
      bit  finishing;
      finishing = 0;
      case (m_mode)
         0: begin
            new_to = load ? int'(load_val) : m_to;
            if (en) begin m_mode = 1; m_cnt = m_to; end
            else m_cnt = new_to;
            m_to = new_to;
         end
         1: begin
            if (!en) begin m_mode = 0; m_cnt = m_to; end
            else if (kick) m_cnt = m_to;
            else if (m_cnt == 0) begin m_mode = 2; m_left = REQN; end
            else m_cnt = m_cnt - 1;
         end
         default: begin
            m_left = m_left - 1;
            if (m_left == 0) begin m_mode = 0; m_cnt = m_to; finishing = 1; end
         end
      endcase
      if (finishing) m_exp = 1;
      else if (clr) m_exp = 0;
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle_inputs();
      en = 0; load = 0; kick = 0; clr = 0; load_val = '0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1;
      @(posedge clk); #1;
      n_checks++;
      if (cnt !== W'(DEF) || warn !== 1'b0 || expired !== 1'b0 || rst_req_n !== 1'b1)
         $display("FAIL reset: cnt=%0d warn=%b exp=%b req_n=%b, need cnt=%0d warn=0 exp=0 req_n=1",
                  cnt, warn, expired, rst_req_n, DEF);
      else n_pass++;
      rst = 0;
      model_reset();
      $display("reset: cnt=%0d req_n=%b", cnt, rst_req_n);
   endtask

   task automatic test_full_timeout();
      int lows;
      test_reset();
      en = 1;
      step();
      n_checks++;
      if (cnt !== W'(DEF)) $display("FAIL e0_cnt: cnt=%0d need %0d", cnt, DEF);
      else n_pass++;
      for (int k = 1; k <= DEF; k++) step();
      n_checks++;
      if (cnt !== 0 || rst_req_n !== 1'b1 || warn !== 1'b1)
         $display("FAIL at_zero: cnt=%0d req_n=%b warn=%b need 0/1/1", cnt, rst_req_n, warn);
      else n_pass++;
      step();
      en = 0;
      lows = 0;
      for (int i = 0; i < 10 && rst_req_n === 1'b0; i++) begin lows++; step(); end
      n_checks++;
      if (lows !== REQN || expired !== 1'b1 || warn !== 1'b0)
         $display("FAIL full_req: low_cycles=%0d exp=%b warn=%b need %0d/1/0", lows, expired, warn, REQN);
      else n_pass++;
      step();
      n_checks++;
      if (cnt !== W'(DEF) || rst_req_n !== 1'b1)
         $display("FAIL back_idle: cnt=%0d req_n=%b need %0d/1", cnt, rst_req_n, DEF);
      else n_pass++;
      $display("full_timeout: low_cycles=%0d expired=%b", lows, expired);
   endtask

   task automatic test_kick_warn();
      test_reset();
      load = 1; load_val = 10;
      step();
      load = 0;
      n_checks++;
      if (cnt !== 10) $display("FAIL load_idle: cnt=%0d need 10", cnt);
      else n_pass++;
      en = 1;
      step();
      while (cnt > 4) step();
      n_checks++;
      if (warn !== 1'b0) $display("FAIL warn_at4: warn=%b need 0", warn);
      else n_pass++;
      step();
      n_checks++;
      if (cnt !== 3 || warn !== 1'b1) $display("FAIL warn_at3: cnt=%0d warn=%b need 3/1", cnt, warn);
      else n_pass++;
      kick = 1; step(); kick = 0;
      n_checks++;
      if (cnt !== 10 || warn !== 1'b0 || rst_req_n !== 1'b1)
         $display("FAIL kick3: cnt=%0d warn=%b req_n=%b need 10/0/1", cnt, warn, rst_req_n);
      else n_pass++;
      for (int i = 0; i < 10; i++) begin
         step();
         n_checks++;
         if (warn !== (cnt <= WARN)) $display("FAIL warn_run: cnt=%0d warn=%b", cnt, warn);
         else n_pass++;
      end
      n_checks++;
      if (cnt !== 0) $display("FAIL reach_zero: cnt=%0d need 0", cnt);
      else n_pass++;
      kick = 1; step(); kick = 0;
      step();
      n_checks++;
      if (cnt !== 9 || rst_req_n !== 1'b1)
         $display("FAIL kick0: cnt=%0d req_n=%b need 9/1", cnt, rst_req_n);
      else n_pass++;
      while (cnt > 5) step();
      load = 1; load_val = 77;
      step();
      load = 0; en = 0;
      step();
      n_checks++;
      if (cnt !== 10 || warn !== 1'b0)
         $display("FAIL en_drop: cnt=%0d warn=%b need 10/0 (load in RUN ignored)", cnt, warn);
      else n_pass++;
      $display("kick_warn: final cnt=%0d", cnt);
   endtask

   task automatic test_zero_timeout();
      int lows;
      test_reset();
      load = 1; load_val = 0; step(); load = 0;
      en = 1;
      step();
      n_checks++;
      if (cnt !== 0 || rst_req_n !== 1'b1) $display("FAIL zero_e0: cnt=%0d req_n=%b need 0/1", cnt, rst_req_n);
      else n_pass++;
      step();
      en = 0;
      lows = 0;
      for (int i = 0; i < 10 && rst_req_n === 1'b0; i++) begin lows++; step(); end
      n_checks++;
      if (lows !== REQN || expired !== 1'b1)
         $display("FAIL zero_req: low_cycles=%0d exp=%b need %0d/1", lows, expired, REQN);
      else n_pass++;
      $display("zero_timeout: low_cycles=%0d", lows);
   endtask

   task automatic test_async_reset();
      test_reset();
      load = 1; load_val = 0; step(); load = 0;
      en = 1; step(); step(); en = 0;
      step();
      n_checks++;
      if (rst_req_n !== 1'b0) $display("FAIL req2_low: req_n=%b need 0", rst_req_n);
      else n_pass++;
      #2 rst = 1;
      #1;
      n_checks++;
      if (rst_req_n !== 1'b1 || cnt !== W'(DEF) || expired !== 1'b0)
         $display("FAIL async_rst: req_n=%b cnt=%0d exp=%b need 1/%0d/0", rst_req_n, cnt, expired, DEF);
      else n_pass++;
      @(negedge clk);
      rst = 0;
      model_reset();
      $display("async_reset: req_n=%b cnt=%0d", rst_req_n, cnt);
   endtask

   task automatic test_clear();
      test_reset();
      load = 1; load_val = 0; step(); load = 0;
      en = 1; step(); step(); en = 0;
      step(); step(); step();
      clr = 1;
      step();
      n_checks++;
      if (expired !== 1'b1 || rst_req_n !== 1'b1)
         $display("FAIL clr_vs_set: exp=%b req_n=%b need 1/1", expired, rst_req_n);
      else n_pass++;
      step();
      clr = 0;
      n_checks++;
      if (expired !== 1'b0) $display("FAIL clr_alone: exp=%b need 0", expired);
      else n_pass++;
      $display("clear: expired=%b", expired);
   endtask

   task automatic test_random();
      int errs;
      test_reset();
      load = 1; load_val = 6; step(); load = 0;
      errs = 0;
      for (int i = 0; i < 3000; i++) begin
         en       = ($urandom_range(0, 19) != 0);
         kick     = ($urandom_range(0, 11) == 0);
         load     = ($urandom_range(0, 7) == 0);
         clr      = ($urandom_range(0, 9) == 0);
         load_val = W'($urandom_range(0, 20));
         step();
         n_checks++;
         if (cnt !== W'(m_cnt) || warn !== (m_mode == 1 && m_cnt <= WARN) ||
             expired !== m_exp[0] || rst_req_n !== (m_mode != 2)) begin
            errs++;
            if (errs <= 10)
               $display("FAIL random[%0d]: cnt=%0d warn=%b exp=%b req_n=%b need %0d/%b/%0d/%b",
                        i, cnt, warn, expired, rst_req_n, m_cnt,
                        (m_mode == 1 && m_cnt <= WARN), m_exp, (m_mode != 2));
         end else n_pass++;
      end
      idle_inputs();
      $display("random: 3000 cycles, %0d mismatching", errs);
   endtask

   initial begin
      model_reset();
      test_reset();
      test_full_timeout();
      test_kick_warn();
      test_zero_timeout();
      test_async_reset();
      test_clear();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
